raabb_cmp_arbiter: RTL
======================

Name: raabb_cmp_arbiter

Overview:
Time-multiplexes one pipelined FloPoCo-format (11-bit exponent, 9-bit fraction) greater-or-equal compare unit among NREQ slab-test requesters in the ray/AABB datapath. Arbitration is round-robin. Accepted operand pairs are registered onto the shared compare unit. A tag pipeline tracks which requester owns each in-flight compare and routes cmp_ge back as a one-cycle response pulse. The compare unit is instantiated beside this block and is driven through the cmp_* ports.

Parameters:
WIDTH, 22, MSB index of an operand; operands are WIDTH+1 bits {exn[2], sign, exp[11], frac[9]}
NREQ, 4, number of requesters (2..8)
CMP_LAT, 3, cycles from cmp_issue high (operands on cmp_a/cmp_b) to the matching cmp_ge being valid
ID_W, 2, requester index width, ceil(log2(NREQ))

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  grant enable; low = no new grants, in-flight ops still complete
req_valid  input  NREQ  per-requester operand pair valid
req_ready  output  NREQ  per-requester accept (combinational, one-hot or zero)
req_a  input  NREQ*(WIDTH+1)  flattened A operands, requester i at [i*(WIDTH+1) +: WIDTH+1]
req_b  input  NREQ*(WIDTH+1)  flattened B operands, same packing
cmp_a  output  WIDTH+1  operand A to shared compare unit (registered)
cmp_b  output  WIDTH+1  operand B to shared compare unit (registered)
cmp_issue  output  1  cmp_a/cmp_b carry a new op this cycle
cmp_ge  input  1  compare result (A >= B), valid CMP_LAT cycles after issue
rsp_valid  output  NREQ  one-cycle response pulse, one-hot or zero
rsp_ge  output  NREQ  result bit per requester, meaningful only with rsp_valid
busy  output  1  any op issued or in flight

Behaviour:
- Reset (async, rst high): all outputs 0; RR pointer = 0; tag pipeline cleared. In-flight ops are discarded and never respond. cmp_a/cmp_b = 0.
- Grant (combinational): when en=1, scan index ptr, ptr+1, ... mod NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all others 0. When en=0 or no requester is valid, req_ready = 0.
- Handshake: req_valid[i] & req_ready[i] at edge T. At most one per cycle. Requesters hold valid and operands until ready.
- Pointer: on handshake, ptr <= (g+1) mod NREQ; otherwise it is unchanged.
- Issue: on handshake at edge T, cmp_a/cmp_b <= req_a[g]/req_b[g] and cmp_issue = 1 during cycle T+1. Without a handshake, cmp_issue = 0 and cmp_a/cmp_b hold their values.
- Tag pipeline: CMP_LAT+1 stages of {v, id}; stage 0 is loaded with {handshake, g}; the pipeline shifts every cycle with no stall.
  - When the final stage is valid, rsp_valid[id] = 1 and rsp_ge[id] = cmp_ge, sampled at that edge and registered.
  - Total latency from handshake edge to rsp_valid: CMP_LAT+2 cycles (5 at default).
- Responses are returned in issue order. There is no response backpressure. Throughput is 1 op/cycle.
- Non-responding rsp_ge bits hold their last value.
- busy = cmp_issue | OR of all tag valid bits.
- en falling mid-stream: no new grants; outstanding ops still respond; busy drops once the pipeline drains.
- Operand encoding (exn, NaN, inf) is passed through unmodified; result semantics belong to the compare unit.
- NREQ not a power of two: the pointer wraps from NREQ-1 to 0 explicitly.

Optional Feature:
RAABB_CMP_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest valid index wins), the RR pointer is removed, and all other timing is unchanged. When undefined, arbitration is round-robin as above.

Test Plan:
- Reset mid-flight: issue 3 ops, assert rst at the cycle the 2nd is in stage 1 -> no rsp_valid pulses afterwards; all outputs 0; ptr restarts at requester 0.
- Single op: req 2 sends A=0x280000 (2.0), B=0x27FE00 (1.0), behavioural compare model CMP_LAT=3 -> req_ready[2] same cycle; cmp_issue at T+1 with cmp_a=0x280000; rsp_valid=4'b0100, rsp_ge[2]=1 at T+5 only.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order at 1/cycle; busy high throughout.
- Swapped operands: req 1 sends A=0x27FE00, B=0x280000, then req 3 sends A=B=0x27FE00 back-to-back -> rsp_ge[1]=0 then rsp_ge[3]=1 on consecutive cycles.
- en gating: en=0 with req 0 valid for 4 cycles -> req_ready=0, cmp_issue=0, busy=0; en=1 -> grant the next cycle.
- Fixed priority (macro defined): reqs 1 and 3 valid continuously -> req 1 granted every cycle and req 3 starved until req 1 drops valid.

Source files
------------

// File: rtl/raabb_cmp_arbiter.sv
// raabb_cmp_arbiter: round-robin arbiter that time-multiplexes one pipelined
// FloPoCo greater-or-equal compare unit among NREQ slab-test requesters.
// Winning operand pairs are registered onto cmp_a/cmp_b, and a tag pipeline
// routes each cmp_ge result back to its owner as a one-cycle rsp_valid pulse.
// Optional macro RAABB_CMP_FIXED_PRIO_EN: fixed priority (lowest valid index
// wins) and no round-robin pointer; all timing is unchanged.
module raabb_cmp_arbiter #(
  parameter int WIDTH   = 22,
  parameter int NREQ    = 4,
  parameter int CMP_LAT = 3,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_a,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_b,
  output logic [WIDTH:0]              cmp_a,
  output logic [WIDTH:0]              cmp_b,
  output logic                        cmp_issue,
  input  logic                        cmp_ge,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [NREQ-1:0]             rsp_ge,
  output logic                        busy
);

  localparam int OW = WIDTH + 1;

  logic [ID_W-1:0] base_s;
  logic [ID_W:0]   idx_s;
  logic            found_s;
  logic [ID_W-1:0] gnt_id_s;
  logic [NREQ-1:0] gnt_s;
  logic [OW-1:0]   sel_a_s;
  logic [OW-1:0]   sel_b_s;

  logic [CMP_LAT:0] tag_v_r;
  logic [ID_W-1:0]  tag_id_r [CMP_LAT+1];

`ifdef RAABB_CMP_FIXED_PRIO_EN
  // Fixed priority always starts the scan at requester 0.
  assign base_s = '0;
`else
  logic [ID_W-1:0] ptr_r;
  assign base_s = ptr_r;

  // Round-robin pointer: advance past the granted requester, explicit wrap
  // so non-power-of-two NREQ never indexes a missing requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (found_s) begin
      if (gnt_id_s == ID_W'(NREQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gnt_id_s + ID_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Grant scan: first valid requester at base, base+1, ... (mod NREQ) wins.
  always_comb begin
    gnt_s    = '0;
    gnt_id_s = '0;
    found_s  = 1'b0;
    idx_s    = '0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = {1'b0, base_s} + (ID_W+1)'(k);
        if (idx_s >= (ID_W+1)'(NREQ)) begin
          idx_s = idx_s - (ID_W+1)'(NREQ);
        end else begin
          idx_s = idx_s;
        end
        if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
          found_s  = 1'b1;
          gnt_id_s = idx_s[ID_W-1:0];
        end else begin
          found_s  = found_s;
        end
      end
      if (found_s) begin
        gnt_s[gnt_id_s] = 1'b1;
      end else begin
        gnt_s = '0;
      end
    end else begin
      gnt_s = '0;
    end
  end

  assign req_ready = gnt_s;
  assign sel_a_s   = req_a[int'(gnt_id_s)*OW +: OW];
  assign sel_b_s   = req_b[int'(gnt_id_s)*OW +: OW];

  // Issue register: latch the winner's operands; hold them when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_a     <= '0;
      cmp_b     <= '0;
      cmp_issue <= 1'b0;
    end else if (found_s) begin
      cmp_a     <= sel_a_s;
      cmp_b     <= sel_b_s;
      cmp_issue <= 1'b1;
    end else begin
      cmp_a     <= cmp_a;
      cmp_b     <= cmp_b;
      cmp_issue <= 1'b0;
    end
  end

  // Tag pipeline: stage 0 takes {handshake, grant id}; shifts every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r <= '0;
      for (int s = 0; s <= CMP_LAT; s++) begin
        tag_id_r[s] <= '0;
      end
    end else begin
      tag_v_r     <= {tag_v_r[CMP_LAT-1:0], found_s};
      tag_id_r[0] <= gnt_id_s;
      for (int s = 1; s <= CMP_LAT; s++) begin
        tag_id_r[s] <= tag_id_r[s-1];
      end
    end
  end

  // Response: pulse the owner's rsp_valid and capture cmp_ge; other rsp_ge hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_ge    <= '0;
    end else begin
      rsp_valid <= '0;
      if (tag_v_r[CMP_LAT]) begin
        rsp_valid[tag_id_r[CMP_LAT]] <= 1'b1;
        rsp_ge[tag_id_r[CMP_LAT]]    <= cmp_ge;
      end else begin
        rsp_ge <= rsp_ge;
      end
    end
  end

  assign busy = cmp_issue | (|tag_v_r);

endmodule
